tcm_memory: RTL and testbench

Parametrised, pipelined successor to the flat instruction/data memory: a tightly coupled dual-port RAM with an instruction fetch port and a load/store port. It adds configurable depth and read latency, valid/ready request handshakes, size-aware loads with sign/zero extension, lane-shifted stores, alignment and range faults, and a reset-time clear sequencer instead of simulation-only initialisation. It sits between the core's fetch/LSU stages and the word array.

---
 rtl/tcm_memory.sv | 188 ++++++++++++++++++
 tb/tb_tcm_memory.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_memory.sv
// Tightly coupled dual-port word RAM: fetch port plus size-aware load/store port,
// LATENCY-deep response pipelines, and a reset-time clear sequencer.
module tcm_memory #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_inst_req,
   input  logic [31:0] i_inst_address,
   output logic        o_inst_ready,
   output logic        o_inst_valid,
   output logic [31:0] o_instruction,
   output logic        o_inst_fault,
   input  logic        i_data_req,
   input  logic        i_data_we,
   input  logic [1:0]  i_data_size,
   input  logic        i_data_unsigned,
   input  logic [31:0] i_data_address,
   input  logic [31:0] i_data_wdata,
   output logic        o_data_ready,
   output logic        o_data_valid,
   output logic [31:0] o_data_rdata,
   output logic        o_data_fault
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t          state_r;
   logic [AW-1:0]   clr_ptr_r;
   logic            ready_r;
   logic [31:0]     mem_r [DEPTH_WORDS];

   logic            inst_v_r [LATENCY];
   logic            inst_f_r [LATENCY];
   logic [31:0]     inst_d_r [LATENCY];
   logic            data_v_r [LATENCY];
   logic            data_f_r [LATENCY];
   logic [31:0]     data_d_r [LATENCY];

   logic [AW-1:0]   i_idx_s;
   logic            i_fault_s;
   logic            i_acc_s;
   logic [31:0]     i_rdata_s;
   logic [AW-1:0]   d_idx_s;
   logic            d_fault_s;
   logic            d_acc_s;
   logic            d_wr_s;
   logic [3:0]      d_mask_s;
   logic [31:0]     d_wdata_s;
   logic [31:0]     d_rdata_s;

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   byte_mask = 4'b0001 << lo;
         2'b01:   byte_mask = 4'b0011 << lo;
         2'b10:   byte_mask = 4'b1111;
         default: byte_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic data_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   data_misaligned = 1'b0;
         2'b01:   data_misaligned = lo[0];
         2'b10:   data_misaligned = |lo;
         default: data_misaligned = 1'b1;
      endcase
   endfunction

   // Lane select shifts the addressed byte/half down to bit 0 before extension.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
      logic [31:0] sh;
      sh = word >> {lo, 3'b000};
      case (size)
         2'b00:   load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'b01:   load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         2'b10:   load_extend = word;
         default: load_extend = 32'h0000_0000;
      endcase
   endfunction

   // Request decode: indices, faults, acceptance, read data and store lanes.
   always_comb begin
      i_idx_s   = i_inst_address[AW+1:2];
      i_fault_s = (|i_inst_address[1:0]) | (|i_inst_address[31:AW+2]);
      i_acc_s   = i_inst_req & ready_r & ~i_rst;
      i_rdata_s = i_fault_s ? 32'h0000_0000 : mem_r[i_idx_s];

      d_idx_s   = i_data_address[AW+1:2];
      d_fault_s = data_misaligned(i_data_size, i_data_address[1:0]) | (|i_data_address[31:AW+2]);
      d_acc_s   = i_data_req & ready_r & ~i_rst;
      d_wr_s    = d_acc_s & i_data_we & ~d_fault_s;
      d_mask_s  = byte_mask(i_data_size, i_data_address[1:0]);
      d_wdata_s = i_data_wdata << {i_data_address[1:0], 3'b000};
      d_rdata_s = (d_fault_s | i_data_we) ? 32'h0000_0000 :
                  load_extend(mem_r[d_idx_s], i_data_size, i_data_address[1:0], i_data_unsigned);
   end

   // Clear/run sequencer; ready rises on the edge that clears the last word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r   <= ST_CLEAR;
         clr_ptr_r <= {AW{1'b0}};
         ready_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               clr_ptr_r <= clr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
               if (clr_ptr_r == AW'(DEPTH_WORDS - 1)) begin
                  state_r <= ST_RUN;
                  ready_r <= 1'b1;
               end else begin
                  state_r <= ST_CLEAR;
                  ready_r <= 1'b0;
               end
            end
            ST_RUN: begin
               state_r <= ST_RUN;
               ready_r <= 1'b1;
            end
            default: begin
               state_r   <= ST_CLEAR;
               clr_ptr_r <= {AW{1'b0}};
               ready_r   <= 1'b0;
            end
         endcase
      end
   end

   // Single write port shared by the clear sequencer and byte-masked stores.
   always_ff @(posedge i_clk) begin
      if (state_r == ST_CLEAR) begin
         mem_r[clr_ptr_r] <= 32'h0000_0000;
      end else if (d_wr_s) begin
         for (int b = 0; b < 4; b++) begin
            if (d_mask_s[b]) begin
               mem_r[d_idx_s][8*b +: 8] <= d_wdata_s[8*b +: 8];
            end
         end
      end
   end

   // Response pipelines: stage 0 captures at the accepting edge, last stage drives outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            inst_v_r[i] <= 1'b0;
            inst_f_r[i] <= 1'b0;
            inst_d_r[i] <= 32'h0000_0000;
            data_v_r[i] <= 1'b0;
            data_f_r[i] <= 1'b0;
            data_d_r[i] <= 32'h0000_0000;
         end
      end else begin
         inst_v_r[0] <= i_acc_s;
         inst_f_r[0] <= i_acc_s & i_fault_s;
         inst_d_r[0] <= i_acc_s ? i_rdata_s : 32'h0000_0000;
         data_v_r[0] <= d_acc_s;
         data_f_r[0] <= d_acc_s & d_fault_s;
         data_d_r[0] <= d_acc_s ? d_rdata_s : 32'h0000_0000;
         for (int i = 1; i < LATENCY; i++) begin
            inst_v_r[i] <= inst_v_r[i-1];
            inst_f_r[i] <= inst_f_r[i-1];
            inst_d_r[i] <= inst_d_r[i-1];
            data_v_r[i] <= data_v_r[i-1];
            data_f_r[i] <= data_f_r[i-1];
            data_d_r[i] <= data_d_r[i-1];
         end
      end
   end

   assign o_inst_ready  = ready_r;
   assign o_data_ready  = ready_r;
   assign o_inst_valid  = inst_v_r[LATENCY-1];
   assign o_inst_fault  = inst_f_r[LATENCY-1];
   assign o_instruction = inst_d_r[LATENCY-1];
   assign o_data_valid  = data_v_r[LATENCY-1];
   assign o_data_fault  = data_f_r[LATENCY-1];
   assign o_data_rdata  = data_d_r[LATENCY-1];

endmodule

// File: tb/tb_tcm_memory.sv
// Scoreboard bench for tcm_memory: expected responses queued at issue, checked on valid.
module tb_tcm_memory;
   localparam int DEPTH = 1024;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_address;
   logic        inst_ready, inst_valid, inst_fault;
   logic [31:0] instruction;
   logic        data_req, data_we, data_unsigned;
   logic [1:0]  data_size;
   logic [31:0] data_address, data_wdata;
   logic        data_ready, data_valid, data_fault;
   logic [31:0] data_rdata;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          due;
   } resp_t;

   resp_t       iq[$];
   resp_t       dq[$];
   logic [31:0] model_mem [DEPTH];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   logic        ready_exp = 1'b0;

   always #5 clk = ~clk;

   tcm_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_inst_req(inst_req), .i_inst_address(inst_address),
      .o_inst_ready(inst_ready), .o_inst_valid(inst_valid),
      .o_instruction(instruction), .o_inst_fault(inst_fault),
      .i_data_req(data_req), .i_data_we(data_we), .i_data_size(data_size),
      .i_data_unsigned(data_unsigned), .i_data_address(data_address),
      .i_data_wdata(data_wdata), .o_data_ready(data_ready),
      .o_data_valid(data_valid), .o_data_rdata(data_rdata), .o_data_fault(data_fault)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Pop and compare one expected response per valid pulse on each port.
   always @(negedge clk) begin
      resp_t r;
      if (inst_valid === 1'b1) begin
         if (iq.size() == 0) check_val("inst_unexpected_valid", 32'd1, 32'd0);
         else begin
            r = iq.pop_front();
            check_val("inst_data", instruction, r.data);
            check_val("inst_fault", {31'd0, inst_fault}, {31'd0, r.fault});
            check_val("inst_cycle", cyc, r.due);
         end
      end
      if (data_valid === 1'b1) begin
         if (dq.size() == 0) check_val("data_unexpected_valid", 32'd1, 32'd0);
         else begin
            r = dq.pop_front();
            check_val("data_rdata", data_rdata, r.data);
            check_val("data_fault", {31'd0, data_fault}, {31'd0, r.fault});
            check_val("data_cycle", cyc, r.due);
         end
      end
   end

   function automatic logic model_dfault(input logic [31:0] a, input logic [1:0] size);
      logic oor;
      oor = (a[31:2] >= 30'(DEPTH));
      case (size)
         2'b00:   return oor;
         2'b01:   return oor || a[0];
         2'b10:   return oor || (a[1:0] != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = model_mem[a[11:2]];
      case (a[1:0])
         2'd0: b = w[7:0];
         2'd1: b = w[15:8];
         2'd2: b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      if (size == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
      else if (size == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
      else return w;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
      int n;
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++)
         model_mem[a[11:2]][8*(int'(a[1:0]) + k) +: 8] = wd[8*k +: 8];
   endtask

   // Drive one cycle of requests at a negedge; queue expectations for accepted ones.
   task automatic drive(input logic ireq, input logic [31:0] ia, input logic dreq, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] da, input logic [31:0] wd);
      resp_t r;
      inst_req = ireq; inst_address = ia;
      data_req = dreq; data_we = we; data_size = size; data_unsigned = uns;
      data_address = da; data_wdata = wd;
      if (ireq && ready_exp) begin
         r.fault = (ia[1:0] != 2'b00) || (ia[31:2] >= 30'(DEPTH));
         r.data  = r.fault ? 32'd0 : model_mem[ia[11:2]];
         r.due   = cyc + LAT;
         iq.push_back(r);
      end
      if (dreq && ready_exp) begin
         r.fault = model_dfault(da, size);
         r.data  = (r.fault || we) ? 32'd0 : model_load(da, size, uns);
         r.due   = cyc + LAT;
         dq.push_back(r);
         if (!r.fault && we) model_store(da, size, wd);
      end
      @(negedge clk);
      inst_req = 1'b0;
      data_req = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [1:0] size, input logic uns);
      drive(1'b0, 32'd0, 1'b1, 1'b0, size, uns, a, 32'd0);
   endtask

   task automatic store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
      drive(1'b0, 32'd0, 1'b1, 1'b1, size, 1'b0, a, wd);
   endtask

   task automatic fetch(input logic [31:0] a);
      drive(1'b1, a, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset(input logic poke);
      int lowcnt;
      rst = 1'b1;
      ready_exp = 1'b0;
      iq.delete();
      dq.delete();
      repeat (3) @(negedge clk);
      check_val("rst_ready", {30'd0, inst_ready, data_ready}, 32'd0);
      check_val("rst_valid", {30'd0, inst_valid, data_valid}, 32'd0);
      check_val("rst_data", instruction | data_rdata, 32'd0);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      rst = 1'b0;
      lowcnt = 0;
      while (inst_ready !== 1'b1 && lowcnt < 3000) begin
         lowcnt++;
         inst_req = poke && (lowcnt < 10);
         data_req = poke && (lowcnt < 10);
         @(negedge clk);
      end
      inst_req = 1'b0;
      data_req = 1'b0;
      check_val("clear_cycles", lowcnt, DEPTH);
      check_val("data_ready_run", {31'd0, data_ready}, 32'd1);
      ready_exp = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      inst_req = 1'b0; inst_address = 32'd0;
      data_req = 1'b0; data_we = 1'b0; data_size = 2'b10; data_unsigned = 1'b0;
      data_address = 32'd0; data_wdata = 32'd0;
      @(negedge clk);
      do_reset(1'b0);

      // Cleared memory reads as zero
      load(32'h0000_0000, 2'b10, 1'b0);
      load(32'h0000_0FFC, 2'b10, 1'b0);
      load(32'h0000_0201, 2'b00, 1'b0);
      fetch(32'h0000_0FFC);

      // Size-aware loads with extension
      store(32'h0000_0040, 2'b10, 32'h8000_00F0);
      load(32'h0000_0040, 2'b00, 1'b0);
      load(32'h0000_0043, 2'b00, 1'b1);
      load(32'h0000_0042, 2'b01, 1'b0);
      load(32'h0000_0040, 2'b01, 1'b1);
      load(32'h0000_0040, 2'b10, 1'b1);

      // Lane-shifted partial stores
      store(32'h0000_0004, 2'b10, 32'h1122_3344);
      store(32'h0000_0006, 2'b01, 32'h0000_BEEF);
      load(32'h0000_0004, 2'b10, 1'b0);
      store(32'h0000_0009, 2'b00, 32'hFFFF_FF5A);
      load(32'h0000_0008, 2'b10, 1'b0);
      load(32'h0000_0009, 2'b00, 1'b0);

      // Faults: misaligned, out of range, reserved size; memory must be untouched
      load(32'h0000_0002, 2'b10, 1'b0);
      store(32'h0000_0005, 2'b01, 32'h0000_FFFF);
      fetch(32'h0000_1001);
      fetch(32'h0000_1000);
      load(32'h0000_1000, 2'b10, 1'b0);
      store(32'h0000_0004, 2'b11, 32'hDEAD_BEEF);
      store(32'h8000_0004, 2'b10, 32'hDEAD_BEEF);
      load(32'h0000_0004, 2'b10, 1'b0);

      // Same-edge store and fetch: read sees pre-store contents
      store(32'h0000_0010, 2'b10, 32'h1234_5678);
      drive(1'b1, 32'h0000_0010, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hAAAA_AAAA);
      fetch(32'h0000_0010);

      // Back-to-back traffic on both ports
      drive(1'b1, 32'h0000_0040, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0);
      drive(1'b1, 32'h0000_0004, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0043, 32'd0);
      drive(1'b1, 32'h0000_0002, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'd0);
      drive(1'b1, 32'h0000_0008, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
      repeat (LAT + 2) @(negedge clk);
      check_val("drain1_inst", iq.size(), 32'd0);
      check_val("drain1_data", dq.size(), 32'd0);

      // Reset with two loads in flight: no responses, clear re-entered
      load(32'h0000_0040, 2'b10, 1'b0);
      load(32'h0000_0004, 2'b10, 1'b0);
      do_reset(1'b1);
      load(32'h0000_0040, 2'b10, 1'b0);
      fetch(32'h0000_0010);
      load(32'h0000_0004, 2'b10, 1'b0);

      repeat (LAT + 4) @(negedge clk);
      check_val("drain2_inst", iq.size(), 32'd0);
      check_val("drain2_data", dq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
